regfile_scoreboard: RTL and testbench

- Parametrised multi-port integer register file with an integrated per-register scoreboard (busy bit plus owner tag) for the superscalar issue stage.
- Replaces the fixed 4-read/2-write register file. Width, depth and port counts are generic.
- Same-cycle writeback-to-read bypass is kept; the block also tracks pending writers so issue logic can detect RAW hazards.
- Sits between decode/issue and the execute writeback buses.

---
 rtl/regfile_scoreboard.sv | 123 ++++++++++++
 tb/tb_regfile_scoreboard.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// Multi-port integer register file with a per-register scoreboard.
// Reads are combinational with writeback bypass; busy/owner track the
// pending writer of each register so issue logic can spot RAW hazards.
module regfile_scoreboard #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int NRD  = 4,
    parameter int NWR  = 2,
    parameter int NISS = 2,
    parameter int TAGW = 4,
    localparam int AW  = $clog2(NREG)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NRD*AW-1:0]    rd_addr_i,
    output logic [NRD*XLEN-1:0]  rd_dout_o,
    output logic [NRD-1:0]       rd_busy_o,
    input  logic [NWR-1:0]       wr_en_i,
    input  logic [NWR*AW-1:0]    wr_addr_i,
    input  logic [NWR*XLEN-1:0]  wr_din_i,
    input  logic [NWR*TAGW-1:0]  wr_tag_i,
    input  logic [NISS-1:0]      iss_en_i,
    input  logic [NISS*AW-1:0]   iss_addr_i,
    input  logic [NISS*TAGW-1:0] iss_tag_i,
    input  logic                 flush_i,
    output logic [NREG-1:0]      busy_vec_o
);

    logic [XLEN-1:0] mem_q   [NREG];
    logic [XLEN-1:0] mem_d   [NREG];
    logic [TAGW-1:0] owner_q [NREG];
    logic [TAGW-1:0] owner_d [NREG];
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    // Read ports: youngest matching writeback bypasses storage; a matching
    // writeback tag hides the busy bit that is about to be cleared.
    always_comb begin
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] rdata;
        logic            clr;
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        rd_dout_o = '0;
        rd_busy_o = '0;
        ra        = '0;
        rdata     = '0;
        clr       = 1'b0;
        for (int i = 0; i < NRD; i++) begin
            ra    = rd_addr_i[i*AW +: AW];
            rdata = mem_q[ra];
            clr   = 1'b0;
            for (int j = 0; j < NWR; j++) begin
                if (wr_en_i[j] && wr_addr_i[j*AW +: AW] == ra) begin
                    rdata = wr_din_i[j*XLEN +: XLEN];
                    if (wr_tag_i[j*TAGW +: TAGW] == owner_q[ra]) begin
                        clr = 1'b1;
                    end
                end
            end
            if (ra == '0) begin
                rdata = '0;
            end
            rd_dout_o[i*XLEN +: XLEN] = rdata;
            rd_busy_o[i]              = busy_q[ra] & ~clr & (ra != '0);
        end
    end

    // Next state: data writes always land; flush beats issue, issue beats
    // writeback clear, and higher port indices win within each group.
    always_comb begin
        logic [AW-1:0] wa;
        mem_d   = mem_q;
        owner_d = owner_q;
        busy_d  = busy_q;
        wa      = '0;
        for (int j = 0; j < NWR; j++) begin
            wa = wr_addr_i[j*AW +: AW];
            if (wr_en_i[j] && wa != '0) begin
                mem_d[wa] = wr_din_i[j*XLEN +: XLEN];
            end
        end
        if (flush_i) begin
            busy_d = '0;
        end else begin
            // Clears compare against the owner held before this edge.
            for (int j = 0; j < NWR; j++) begin
                wa = wr_addr_i[j*AW +: AW];
                if (wr_en_i[j] && wr_tag_i[j*TAGW +: TAGW] == owner_q[wa]) begin
                    busy_d[wa] = 1'b0;
                end
            end
            // Issues run last so they override a same-cycle clear.
            for (int k = 0; k < NISS; k++) begin
                wa = iss_addr_i[k*AW +: AW];
                if (iss_en_i[k] && wa != '0) begin
                    busy_d[wa]  = 1'b1;
                    owner_d[wa] = iss_tag_i[k*TAGW +: TAGW];
                end
            end
        end
        busy_d[0] = 1'b0;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // NOTE: storage is reset on purpose: reads must return 0 after reset, not stale contents.
            for (int n = 0; n < NREG; n++) begin
                mem_q[n]   <= '0;
                owner_q[n] <= '0;
            end
            busy_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            mem_q   <= mem_d;
            owner_q <= owner_d;
            busy_q  <= busy_d;
        end
    end

    assign busy_vec_o = {busy_q[NREG-1:1], 1'b0};

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: directed scenarios with
// literal expectations, then randomized traffic against a behavioural model.
module tb_regfile_scoreboard;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NRD  = 4;
    localparam int NWR  = 2;
    localparam int NISS = 2;
    localparam int TAGW = 4;
    localparam int AW   = 5;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NRD*AW-1:0]    rd_addr;
    logic [NRD*XLEN-1:0]  rd_dout;
    logic [NRD-1:0]       rd_busy;
    logic [NWR-1:0]       wr_en;
    logic [NWR*AW-1:0]    wr_addr;
    logic [NWR*XLEN-1:0]  wr_din;
    logic [NWR*TAGW-1:0]  wr_tag;
    logic [NISS-1:0]      iss_en;
    logic [NISS*AW-1:0]   iss_addr;
    logic [NISS*TAGW-1:0] iss_tag;
    logic                 flush;
    logic [NREG-1:0]      busy_vec;

    int n_checks = 0;
    int n_errors = 0;

    regfile_scoreboard #(
        .XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .NISS(NISS), .TAGW(TAGW)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .rd_addr_i(rd_addr), .rd_dout_o(rd_dout), .rd_busy_o(rd_busy),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_din_i(wr_din), .wr_tag_i(wr_tag),
        .iss_en_i(iss_en), .iss_addr_i(iss_addr), .iss_tag_i(iss_tag),
        .flush_i(flush), .busy_vec_o(busy_vec)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [XLEN-1:0] m_mem   [NREG];
    logic            m_busy  [NREG];
    logic [TAGW-1:0] m_owner [NREG];
    bit              m_valid = 1'b0;

    function automatic logic [XLEN-1:0] model_data(input int a);
        logic [XLEN-1:0] d;
        if (a == 0) return '0;
        d = m_mem[a];
        for (int j = 0; j < NWR; j++)
            if (wr_en[j] && int'(wr_addr[j*AW +: AW]) == a) d = wr_din[j*XLEN +: XLEN];
        return d;
    endfunction

    function automatic logic model_busy(input int a);
        if (a == 0) return 1'b0;
        for (int j = 0; j < NWR; j++)
            if (wr_en[j] && int'(wr_addr[j*AW +: AW]) == a && wr_tag[j*TAGW +: TAGW] == m_owner[a])
                return 1'b0;
        return m_busy[a];
    endfunction

    always @(posedge clk) begin
        bit              issued [NREG];
        logic [TAGW-1:0] itag   [NREG];
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                m_mem[r] = '0; m_busy[r] = 1'b0; m_owner[r] = '0;
            end
            m_valid = 1'b1;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                issued[r] = 1'b0; itag[r] = '0;
            end
            for (int k = 0; k < NISS; k++)
                if (iss_en[k] && iss_addr[k*AW +: AW] != 0) begin
                    issued[iss_addr[k*AW +: AW]] = 1'b1;
                    itag[iss_addr[k*AW +: AW]]   = iss_tag[k*TAGW +: TAGW];
                end
            for (int r = 1; r < NREG; r++) begin
                if (flush) m_busy[r] = 1'b0;
                else if (issued[r]) begin
                    m_busy[r] = 1'b1; m_owner[r] = itag[r];
                end else if (!model_busy(r)) m_busy[r] = 1'b0;
            end
            for (int j = 0; j < NWR; j++)
                if (wr_en[j] && wr_addr[j*AW +: AW] != 0)
                    m_mem[wr_addr[j*AW +: AW]] = wr_din[j*XLEN +: XLEN];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: every cycle once the model has seen a reset.
    always @(negedge clk) begin
        if (m_valid) begin
            for (int i = 0; i < NRD; i++) begin
                int a;
                a = int'(rd_addr[i*AW +: AW]);
                check($sformatf("rd_dout[%0d] a=%0d", i, a), rd_dout[i*XLEN +: XLEN], model_data(a));
                check($sformatf("rd_busy[%0d] a=%0d", i, a), rd_busy[i], model_busy(a));
            end
            for (int r = 0; r < NREG; r++)
                check($sformatf("busy_vec[%0d]", r), busy_vec[r], (r == 0) ? 1'b0 : m_busy[r]);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        rst = 1'b0; flush = 1'b0;
        rd_addr = '0; wr_en = '0; wr_addr = '0; wr_din = '0; wr_tag = '0;
        iss_en = '0; iss_addr = '0; iss_tag = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_rd(input int i, input int a);
        rd_addr[i*AW +: AW] = AW'(a);
    endtask

    task automatic set_wr(input int j, input int a, input logic [XLEN-1:0] d, input int t);
        wr_en[j] = 1'b1;
        wr_addr[j*AW +: AW]     = AW'(a);
        wr_din[j*XLEN +: XLEN]  = d;
        wr_tag[j*TAGW +: TAGW]  = TAGW'(t);
    endtask

    task automatic set_iss(input int k, input int a, input int t);
        iss_en[k] = 1'b1;
        iss_addr[k*AW +: AW]    = AW'(a);
        iss_tag[k*TAGW +: TAGW] = TAGW'(t);
    endtask

    initial begin
        idle();
        rst = 1'b1;
        tick(); tick();

        // Reset after random writes, held two cycles.
        for (int c = 0; c < 8; c++) begin
            idle();
            set_wr(0, 5 + c, $urandom, 0);
            set_iss(0, 5 + c, c);
            tick();
        end
        idle(); rst = 1'b1; tick(); tick();
        idle();
        for (int i = 0; i < NRD; i++) set_rd(i, 5 + i);
        settle();
        for (int i = 0; i < NRD; i++) check($sformatf("post-reset rd_dout[%0d]", i), rd_dout[i*XLEN +: XLEN], 0);
        check("post-reset busy_vec", busy_vec, 0);

        // Reset mid-operation with a live issue.
        idle(); set_iss(0, 7, 3); rst = 1'b1; tick();
        idle(); settle();
        check("reset beats issue busy_vec", busy_vec, 0);

        // Bypass priority: highest writeback port wins, visible same cycle.
        idle(); set_wr(0, 5, 32'hAAAA_0000, 0); set_wr(1, 5, 32'h5555_1111, 0); set_rd(0, 5);
        settle();
        check("bypass rd_dout0", rd_dout[0 +: XLEN], 32'h5555_1111);
        tick();
        idle(); set_rd(0, 5); settle();
        check("mem[5] after edge", rd_dout[0 +: XLEN], 32'h5555_1111);
        idle(); set_wr(0, 0, 32'hFFFF_FFFF, 0); set_rd(1, 0); settle();
        check("r0 bypass reads 0", rd_dout[XLEN +: XLEN], 0);
        tick();
        idle(); set_rd(1, 0); settle();
        check("r0 stays 0", rd_dout[XLEN +: XLEN], 0);

        // Scoreboard lifecycle on r7.
        idle(); set_iss(0, 7, 3); tick();
        idle(); set_rd(0, 7); settle();
        check("r7 busy_vec after issue", busy_vec[7], 1);
        check("r7 rd_busy after issue", rd_busy[0], 1);
        set_wr(0, 7, 32'h1234, 3); settle();
        check("r7 wb rd_busy", rd_busy[0], 0);
        check("r7 wb rd_dout", rd_dout[0 +: XLEN], 32'h1234);
        tick();
        idle(); set_rd(0, 7); settle();
        check("r7 busy_vec cleared", busy_vec[7], 0);

        // Stale writer tag on r9.
        idle(); set_iss(0, 9, 1); tick();
        idle(); set_iss(0, 9, 2); tick();
        idle(); set_wr(0, 9, 32'hDEAD, 1); set_rd(0, 9); settle();
        check("r9 stale wb rd_busy", rd_busy[0], 1);
        check("r9 stale wb data", rd_dout[0 +: XLEN], 32'hDEAD);
        tick();
        idle(); set_rd(0, 9); settle();
        check("r9 still busy", busy_vec[9], 1);
        check("mem[9]", rd_dout[0 +: XLEN], 32'hDEAD);
        set_wr(1, 9, 32'hBEEF, 2); settle();
        check("r9 matching wb rd_busy", rd_busy[0], 0);
        tick();
        idle(); settle();
        check("r9 cleared", busy_vec[9], 0);

        // Issue collisions on r4, plus a matching writeback in that cycle.
        idle(); set_iss(0, 4, 2); tick();
        idle(); set_iss(0, 4, 5); set_iss(1, 4, 6); set_wr(0, 4, 32'h44, 2); tick();
        idle(); set_rd(0, 4); settle();
        check("r4 issue beats wb", busy_vec[4], 1);
        set_wr(0, 4, 32'h45, 5); settle();
        check("r4 owner not 5", rd_busy[0], 1);
        set_wr(0, 4, 32'h46, 6); settle();
        check("r4 owner is 6", rd_busy[0], 0);
        tick();
        idle(); settle();
        check("r4 cleared by tag 6", busy_vec[4], 0);

        // Flush drops same-cycle issue, keeps same-cycle data write.
        idle(); set_iss(0, 1, 1); set_iss(1, 2, 2); tick();
        idle(); set_iss(0, 3, 3); tick();
        idle(); settle();
        check("busy r1..r3", busy_vec[3:0], 4'b1110);
        flush = 1'b1; set_iss(0, 10, 7); set_wr(0, 2, 32'h77, 9); tick();
        idle(); set_rd(0, 2); set_rd(1, 10); settle();
        check("flush busy_vec", busy_vec, 0);
        check("flush r10 not busy", rd_busy[1], 0);
        check("flush mem[2]", rd_dout[0 +: XLEN], 32'h77);

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            idle();
            rst   = ($urandom_range(0, 299) == 0);
            flush = ($urandom_range(0, 31) == 0);
            for (int j = 0; j < NWR; j++)
                if ($urandom_range(0, 3) != 0) begin
                    int a;
                    a = $urandom_range(0, 15);
                    set_wr(j, a, $urandom,
                           ($urandom_range(0, 1) == 1) ? int'(m_owner[a]) : $urandom_range(0, 15));
                end
            for (int k = 0; k < NISS; k++)
                if ($urandom_range(0, 2) == 0) set_iss(k, $urandom_range(0, 15), $urandom_range(0, 15));
            for (int i = 0; i < NRD; i++) set_rd(i, $urandom_range(0, (i == 3) ? 31 : 15));
            if ($urandom_range(0, 1) == 1) rd_addr[0 +: AW] = wr_addr[0 +: AW];
            if ($urandom_range(0, 1) == 1) rd_addr[AW +: AW] = wr_addr[AW +: AW];
            tick();
        end
        idle();
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
